// File: rtl/mips_mem_pkg.sv
// Shared types for the CPU memory arbiter: FSM states, access sizes, requester ids.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Encoding 2'b11 is an illegal size and is rejected with an error ack.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic REQ_INSTR = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/mips_lane_align.sv
// Byte-lane steering for byte/half/word accesses; purely combinational, no backpressure.
// Produces byte enables, misalignment flag, replicated store data and extended load data.
module mips_lane_align
  import mips_mem_pkg::*;
#(
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byteenable,
  output logic        misalign,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Big-endian mirrors the lane: offset k lands on lane 3-k.
    lane = (LITTLE_ENDIAN != 0) ? addr : ~addr;

    case (lane)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = lane[1] ? rword[31:16] : rword[15:0];

    byteenable = 4'b0000;
    misalign   = 1'b0;
    wdata_rep  = 32'h0;
    rdata_ext  = 32'h0;
    case (size)
      SZ_BYTE: begin
        byteenable = 4'b0001 << lane;
        wdata_rep  = {4{wdata[7:0]}};
        rdata_ext  = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misalign   = addr[0];
        byteenable = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        misalign   = (addr != 2'b00);
        byteenable = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = rword;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates fetch and load/store requesters onto one Avalon-MM port; read ack N+3, write ack N+2.
// Bus command held stable under waitrequest; each stall cycle adds one cycle to the ack.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ROUND_ROBIN   = 0,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  state_t      state, state_nxt;
  logic        owner, last_grant;
  logic        reg_we, reg_signed;
  logic [1:0]  reg_size;
  logic [31:0] reg_addr, reg_wdata;

  logic        in_idle, i_pend, d_pend, grant_d, grant_i, grant, bad;
  logic [1:0]  al_addr, al_size;
  logic        al_signed;
  logic [3:0]  al_be;
  logic        al_misalign;
  logic [31:0] al_wdata, al_rdata;

  // In IDLE the aligner checks the live data request; afterwards it works on the latched one.
  always_comb begin
    in_idle   = (state == IDLE);
    al_addr   = in_idle ? d_addr[1:0] : reg_addr[1:0];
    al_size   = in_idle ? d_size      : reg_size;
    al_signed = in_idle ? d_signed    : reg_signed;
  end

  mips_lane_align #(.LITTLE_ENDIAN(LITTLE_ENDIAN)) u_align (
    .addr       (al_addr),
    .size       (al_size),
    .sign_ext   (al_signed),
    .wdata      (reg_wdata),
    .rword      (avm_readdata),
    .byteenable (al_be),
    .misalign   (al_misalign),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata)
  );

  // A requester whose ack is high this cycle is masked so it cannot be re-granted.
  always_comb begin
    i_pend  = i_req & ~i_ack;
    d_pend  = d_req & ~d_ack;
    grant_d = d_pend & (~i_pend | (ROUND_ROBIN == 0) | (last_grant == REQ_INSTR));
    grant_i = i_pend & ~grant_d;
    grant   = in_idle & (grant_d | grant_i);
    bad     = grant_d ? al_misalign : (i_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant && !bad) state_nxt = BUS;
      BUS:     if (!avm_waitrequest) state_nxt = reg_we ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    avm_read       = (state == BUS) & ~reg_we;
    avm_write      = (state == BUS) & reg_we;
    avm_address    = (state == BUS) ? {reg_addr[31:2], 2'b00} : 32'h0;
    avm_byteenable = (state == BUS) ? al_be : 4'b0000;
    avm_writedata  = avm_write ? al_wdata : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_ack      <= 1'b0;
      i_rdata    <= 32'h0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= 32'h0;
      owner      <= REQ_INSTR;
      last_grant <= REQ_INSTR;
      reg_we     <= 1'b0;
      reg_signed <= 1'b0;
      reg_size   <= 2'b00;
      reg_addr   <= 32'h0;
      reg_wdata  <= 32'h0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          owner      <= grant_d ? REQ_DATA : REQ_INSTR;
          last_grant <= grant_d ? REQ_DATA : REQ_INSTR;
          if (bad) begin
            if (grant_d) begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= 32'h0;
            end
          end else if (grant_d) begin
            reg_we     <= d_we;
            reg_size   <= d_size;
            reg_signed <= d_signed;
            reg_addr   <= d_addr;
            reg_wdata  <= d_wdata;
          end else begin
            reg_we     <= 1'b0;
            reg_size   <= SZ_WORD;
            reg_signed <= 1'b0;
            reg_addr   <= i_addr;
            reg_wdata  <= 32'h0;
          end
        end
        BUS: if (!avm_waitrequest && reg_we) d_ack <= 1'b1;
        RESP: begin
          if (owner == REQ_DATA) begin
            d_ack   <= 1'b1;
            d_rdata <= al_rdata;
          end else begin
            i_ack   <= 1'b1;
            i_rdata <= al_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: ack scoreboard plus latency/lane checks against a simple Avalon slave.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_we, d_signed;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        i_ack, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic [31:0] avm_address, avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_read, avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;

  typedef struct {
    logic        port;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   wait_cfg = 0;
  int   wait_cnt = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h8C22_0004;
      32'h0000_0100: return 32'h1234_F678;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Slave: stalls each command for wait_cfg cycles, returns data the cycle after accept.
  assign avm_waitrequest = (avm_read || avm_write) && (wait_cnt < wait_cfg);
  always @(posedge clk) begin
    if (avm_read || avm_write) wait_cnt <= avm_waitrequest ? wait_cnt + 1 : 0;
    else                       wait_cnt <= 0;
    if (avm_read && !avm_waitrequest) avm_readdata <= mem_fn(avm_address);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("ack_overlap", 32'(i_ack & d_ack), 32'h0);
      chk("rd_wr_both", 32'(avm_read & avm_write), 32'h0);
      chk("err_without_ack", 32'(d_err & ~d_ack), 32'h0);
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {30'h0, i_ack, d_ack}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", 32'(d_ack), 32'(e.port));
          chk("ack_err", 32'(d_err), 32'(e.err));
          if (e.chk_rd) chk("ack_rdata", e.port ? d_rdata : i_rdata, e.rdata);
        end
      end
    end
  end

  // One transaction on one port; cycle 0 is the cycle in which the request is first sampled.
  task automatic xact(input logic port, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                      input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err,
                      output int ack_cyc, output int cmd_cyc, output int cmd_cnt,
                      output logic [31:0] c_addr, output logic [3:0] c_be,
                      output logic [31:0] c_wd, output logic stable);
    @(posedge clk); #1;
    wait_cfg = waits;
    if (port) begin
      d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    exp_q.push_back('{port, chk_rd, exp_rd, exp_err});
    ack_cyc = -1; cmd_cyc = -1; cmd_cnt = 0; stable = 1'b1;
    c_addr = 32'h0; c_be = 4'h0; c_wd = 32'h0;
    for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (avm_read || avm_write) begin
        if (cmd_cyc < 0) begin
          cmd_cyc = c; c_addr = avm_address; c_be = avm_byteenable; c_wd = avm_writedata;
        end else if ({avm_address, avm_byteenable, avm_writedata} != {c_addr, c_be, c_wd}) begin
          stable = 1'b0;
        end
        cmd_cnt++;
      end
      if (port ? d_ack : i_ack) ack_cyc = c;
    end
    if (ack_cyc < 0) chk("ack_timeout", 32'(port ? d_ack : i_ack), 32'h1);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
  endtask

  int          ac, cc, cn, d_cyc, i_cyc, f_cmd;
  logic [31:0] ca, cw, fa;
  logic [3:0]  cb;
  logic        st;

  initial begin
    reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_signed = 1'b0;
    d_size = 2'b10; i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    #2;
    chk("rst_acks", {29'h0, i_ack, d_ack, d_err}, 32'h0);
    chk("rst_bus_cmd", {30'h0, avm_read, avm_write}, 32'h0);
    chk("rst_address", avm_address, 32'h0);
    chk("rst_byteenable", 32'(avm_byteenable), 32'h0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Fetch, no wait states.
    xact(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b1, 32'h8C22_0004, 1'b0, ac, cc, cn, ca, cb, cw, st);
    chk("fetch_cmd_cyc", 32'(cc), 32'd1);
    chk("fetch_ack_cyc", 32'(ac), 32'd3);
    chk("fetch_addr", ca, 32'h10);
    chk("fetch_be", 32'(cb), 32'hF);

    // Both requesters at once: data first, fetch issued the cycle after d_ack.
    @(posedge clk); #1;
    wait_cfg = 0;
    d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 32'h20; d_req = 1'b1;
    i_addr = 32'h30; i_req = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, mem_fn(32'h20), 1'b0});
    exp_q.push_back('{1'b0, 1'b1, mem_fn(32'h30), 1'b0});
    d_cyc = -1; i_cyc = -1; f_cmd = -1; fa = 32'h0;
    for (int c = 0; c < 40 && i_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) fa = avm_address;
      if (d_cyc >= 0 && f_cmd < 0 && avm_read) f_cmd = c;
      if (d_ack) begin d_cyc = c; d_req = 1'b0; end
      if (i_ack) begin i_cyc = c; i_req = 1'b0; end
    end
    if (i_cyc < 0) chk("both_timeout", 32'(i_ack), 32'h1);
    chk("both_first_addr", fa, 32'h20);
    chk("both_d_ack_cyc", 32'(d_cyc), 32'd3);
    chk("both_fetch_cmd_cyc", 32'(f_cmd), 32'd4);
    chk("both_i_ack_cyc", 32'(i_cyc), 32'd6);
    i_req = 1'b0; d_req = 1'b0;

    // Store byte at 0x103 with two wait states.
    xact(1'b1, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00AB, 2, 1'b0, 32'h0, 1'b0, ac, cc, cn, ca, cb, cw, st);
    chk("sb_addr", ca, 32'h100);
    chk("sb_be", 32'(cb), 32'h8);
    chk("sb_wdata", cw, 32'hABAB_ABAB);
    chk("sb_held_cycles", 32'(cn), 32'd3);
    chk("sb_stable", 32'(st), 32'h1);
    chk("sb_ack_cyc", 32'(ac), 32'd4);

    // Load lane selection and extension.
    xact(1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 0, 1'b1, 32'hFFFF_FFF6, 1'b0, ac, cc, cn, ca, cb, cw, st);
    chk("lb_ack_cyc", 32'(ac), 32'd3);
    chk("lb_be", 32'(cb), 32'h2);
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 0, 1'b1, 32'h0000_00F6, 1'b0, ac, cc, cn, ca, cb, cw, st);
    xact(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 1'b1, 32'h0000_1234, 1'b0, ac, cc, cn, ca, cb, cw, st);
    chk("lh_be", 32'(cb), 32'hC);
    xact(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, 1'b1, 32'hFFFF_F678, 1'b0, ac, cc, cn, ca, cb, cw, st);
    chk("lh0_be", 32'(cb), 32'h3);

    // Misaligned word and illegal size: error ack next cycle, no bus cycle.
    xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 1'b0, 32'h0, 1'b1, ac, cc, cn, ca, cb, cw, st);
    chk("mis_ack_cyc", 32'(ac), 32'd1);
    chk("mis_no_cmd", 32'(cn), 32'd0);
    xact(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 1'b0, 32'h0, 1'b1, ac, cc, cn, ca, cb, cw, st);
    chk("ill_ack_cyc", 32'(ac), 32'd1);
    chk("ill_no_cmd", 32'(cn), 32'd0);

    // Store half at offset 2, one wait state.
    xact(1'b1, 1'b1, 2'b01, 1'b0, 32'h102, 32'h5555_BEEF, 1, 1'b0, 32'h0, 1'b0, ac, cc, cn, ca, cb, cw, st);
    chk("sh_be", 32'(cb), 32'hC);
    chk("sh_wdata", cw, 32'hBEEF_BEEF);
    chk("sh_ack_cyc", 32'(ac), 32'd3);

    // Load word with one wait state.
    xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'h1234_F678, 1'b0, ac, cc, cn, ca, cb, cw, st);
    chk("lw_wait_ack_cyc", 32'(ac), 32'd4);

    // Misaligned fetch returns zero without a bus cycle.
    xact(1'b0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0, 1'b1, 32'h0, 1'b0, ac, cc, cn, ca, cb, cw, st);
    chk("fmis_ack_cyc", 32'(ac), 32'd1);
    chk("fmis_no_cmd", 32'(cn), 32'd0);

    // Reset during a stalled read abandons it.
    @(posedge clk); #1;
    wait_cfg = 1000; i_addr = 32'h40; i_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_read_before", 32'(avm_read), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid_read_dropped", 32'(avm_read), 32'h0);
    chk("rstmid_no_ack", 32'(i_ack), 32'h0);
    i_req = 1'b0; wait_cfg = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_idle", {30'h0, i_ack, avm_read}, 32'h0);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    xact(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b1, 32'h8C22_0004, 1'b0, ac, cc, cn, ca, cb, cw, st);
    chk("post_rst_ack_cyc", 32'(ac), 32'd3);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
